// File: rtl/fp_mult_round_pack.sv
// rtl/fp_mult_round_pack.sv - FP multiplier final stage: RNE rounding, special-case handling, IEEE-754 single pack
// Two-entry pipeline (round, then classify/pack) with valid/ready and full backpressure.
module fp_mult_round_pack #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter bit          FTZ  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [22:0] in_mant,
  input  logic [8:0]  in_exp,
  input  logic        in_g,
  input  logic        in_r,
  input  logic        in_s,
  input  logic        in_nan,
  input  logic        in_inf,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inx
);

  logic        s1_v_q;
  logic        s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_inx_q;
  logic [22:0] s1_mant_q;
  logic [9:0]  s1_exp_q;

  logic        s2_v_q;
  logic [31:0] z_q;
  logic        ovf_q, unf_q, inx_q;

  logic        s1_load, s2_load;
  logic        round_up;
  logic [23:0] rnd_sum;
  logic [22:0] s1_mant_d;
  logic [9:0]  s1_exp_d;
  logic        s1_inx_d;

  logic [31:0] z_d;
  logic        ovf_d, unf_d, inx_d;

  // A stage may load when empty or when its current content leaves this cycle.
  assign s2_load  = !s2_v_q || out_ready;
  assign s1_load  = !s1_v_q || s2_load;
  assign in_ready = s1_load;

  assign out_valid = s2_v_q;
  assign out_z     = z_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
  assign out_inx   = inx_q;

  // Round to nearest, ties to even.
  always_comb begin
    round_up = in_g & (in_r | in_s | in_mant[0]);
    rnd_sum  = {1'b0, in_mant} + {23'd0, round_up};
    s1_inx_d = in_g | in_r | in_s;
    if (rnd_sum[23]) begin
      s1_mant_d = 23'd0;
      s1_exp_d  = {1'b0, in_exp} + 10'd1;
    end else begin
      s1_mant_d = rnd_sum[22:0];
      s1_exp_d  = {1'b0, in_exp};
    end
  end

  always_comb begin
    z_d   = {s1_sign_q, s1_exp_q[7:0], s1_mant_q};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = s1_inx_q;
    if (s1_nan_q) begin
      z_d   = QNAN;
      inx_d = 1'b0;
    end else if (s1_inf_q) begin
      z_d   = {s1_sign_q, 8'hFF, 23'h0};
      inx_d = 1'b0;
    end else if (s1_zero_q) begin
      z_d   = {s1_sign_q, 31'h0};
      inx_d = 1'b0;
    end else if (s1_exp_q >= 10'd255) begin
      z_d   = {s1_sign_q, 8'hFF, 23'h0};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (FTZ && (s1_exp_q == 10'd0)) begin
      z_d   = {s1_sign_q, 31'h0};
      unf_d = 1'b1;
      inx_d = s1_inx_q | (s1_mant_q != 23'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_nan_q  <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_inx_q  <= 1'b0;
      s1_mant_q <= 23'd0;
      s1_exp_q  <= 10'd0;
      s2_v_q    <= 1'b0;
      z_q       <= 32'd0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inx_q     <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_sign_q <= in_sign;
          s1_nan_q  <= in_nan;
          s1_inf_q  <= in_inf;
          s1_zero_q <= in_zero;
          s1_inx_q  <= s1_inx_d;
          s1_mant_q <= s1_mant_d;
          s1_exp_q  <= s1_exp_d;
        end
      end
      // Output registers only change when a new result arrives, so a stalled beat stays stable.
      if (s2_load) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          z_q   <= z_d;
          ovf_q <= ovf_d;
          unf_q <= unf_d;
          inx_q <= inx_d;
        end
      end
    end
  end

endmodule
